saida_bcd_seq: RTL

Multi-channel, sequential binary-to-BCD converter for the processor's display output path. Each channel captures a DATA_W-bit value on a request pulse; a single shared double-dabble engine converts pending channels one at a time (one bit per clock) and holds the decimal result, sign and valid flag per channel for the seven-segment drivers. Channel 0 carries I/O data (signed); channel 1 carries the program address (unsigned).

---
 rtl/saida_bcd_seq_pkg.sv | 23 ++
 rtl/saida_bcd_seq_if.sv | 23 ++
 rtl/saida_bcd_seq_dabble_step.sv | 25 ++
 rtl/saida_bcd_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/saida_bcd_seq_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
// Holds the engine state encoding, default sizing and the digit-count check.
// Pure declarations; no logic, no latency, no flow control.
package saida_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DIGITS = 10;
  localparam int DEF_NCH    = 2;
  localparam logic [1:0] DEF_SIGNED_MASK = 2'b01;

  // Decimal digits needed for a w-bit magnitude: ceil(w * log10(2)).
  // log10(2) ~= 0.30103, so integer arithmetic is enough for any sane width.
  function automatic int min_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/saida_bcd_seq_if.sv
// Request/result bundle between the display path and the BCD converter.
// Wires only; latency and timing are set by the converter.
// No backpressure: requests are strobes, results are held levels plus a done pulse.
interface saida_bcd_seq_if
  import saida_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIGITS = DEF_DIGITS,
  parameter int NCH    = DEF_NCH
);

  logic [NCH-1:0]          req;
  logic [NCH*DATA_W-1:0]   val;
  logic [NCH*DIGITS*4-1:0] bcd;
  logic [NCH-1:0]          neg;
  logic [NCH-1:0]          valid;
  logic [NCH-1:0]          done;
  logic                    busy;

  modport master (output req, val, input bcd, neg, valid, done, busy);
  modport slave  (input req, val, output bcd, neg, valid, done, busy);

endinterface

// File: rtl/saida_bcd_seq_dabble_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift in one bit.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module bcd_dabble_step #(
  parameter int DIGITS = 10
) (
  input  logic [DIGITS*4-1:0] acc_in,
  input  logic                bit_in,
  output logic [DIGITS*4-1:0] acc_out
);

  logic [DIGITS*4-1:0] corr;

  // Correct each digit so the following doubling carries into the next decade.
  always_comb begin
    corr = acc_in;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_in[d*4 +: 4] >= 4'd5) begin
        corr[d*4 +: 4] = acc_in[d*4 +: 4] + 4'd3;
      end
    end
    acc_out = {corr[DIGITS*4-2:0], bit_in};
  end

endmodule

// File: rtl/saida_bcd_seq.sv
// Multi-channel binary-to-BCD converter sharing one bit-serial double-dabble engine.
// Latency DATA_W+2 edges from request to done on an idle engine; DATA_W+2 cycles per conversion.
// No backpressure: a newer request overwrites an unconverted value (last writer wins).
module saida_bcd_seq
  import saida_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIGITS = DEF_DIGITS,
  parameter int NCH    = DEF_NCH,
  parameter logic [NCH-1:0] SIGNED_MASK = NCH'(DEF_SIGNED_MASK)
) (
  input  logic            clock,
  input  logic            reset,
  saida_bcd_seq_if.slave  bus
);

  localparam int ACC_W = DIGITS * 4;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if (DIGITS < min_digits(DATA_W)) begin : g_digits_too_few
    $error("DIGITS too small to hold a DATA_W-bit magnitude");
  end

  logic [DATA_W-1:0] hold [NCH];
  logic [NCH-1:0]    pend;
  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   cur;
  logic              any_pend;
  logic [DATA_W-1:0] hold_g;
  logic              neg_in;
  logic [DATA_W-1:0] mag;
  logic              flag;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  cnt;

  logic [NCH*ACC_W-1:0] bcd_q;
  logic [NCH-1:0]       neg_q;
  logic [NCH-1:0]       valid_q;
  logic [NCH-1:0]       done_q;

  // Round-robin pick: first pending channel at or after the pointer.
  always_comb begin
    any_pend = 1'b0;
    gnt      = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!any_pend && pend[(int'(ptr) + i) % NCH]) begin
        any_pend = 1'b1;
        gnt      = CH_W'((int'(ptr) + i) % NCH);
      end
    end
    hold_g = hold[gnt];
    neg_in = SIGNED_MASK[gnt] & hold_g[DATA_W-1];
  end

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .acc_in  (acc),
    .bit_in  (mag[DATA_W-1]),
    .acc_out (acc_nxt)
  );

  // Capture requests; a request on the same edge as its grant keeps the channel pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) hold[c] <= '0;
      pend <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.req[c]) begin
          hold[c] <= bus.val[c*DATA_W +: DATA_W];
          pend[c] <= 1'b1;
        end else if (state == S_IDLE && any_pend && gnt == CH_W'(c)) begin
          pend[c] <= 1'b0;
        end
      end
    end
  end

  // Engine: grant and load magnitude, shift DATA_W bits, then publish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      cur   <= '0;
      mag   <= '0;
      flag  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_pend) begin
            cur   <= gnt;
            ptr   <= (gnt == CH_W'(NCH-1)) ? '0 : gnt + CH_W'(1);
            flag  <= neg_in;
            mag   <= neg_in ? (~hold_g + DATA_W'(1)) : hold_g;
            acc   <= '0;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc <= acc_nxt;
          mag <= {mag[DATA_W-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W-1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-channel result registers; only the granted channel is touched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_q   <= '0;
      neg_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      if (state == S_DONE) begin
        bcd_q[cur*ACC_W +: ACC_W] <= acc;
        neg_q[cur]   <= flag;
        valid_q[cur] <= 1'b1;
        done_q[cur]  <= 1'b1;
      end
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.neg   = neg_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state != S_IDLE);

endmodule
